// File: rtl/ppg_pkg.sv
// Shared types for the PPG window framer: sample type, sizing defaults,
// launcher state encoding and the 17-to-16 bit saturation helper.
package ppg_pkg;

    localparam int WIN_LEN_DEF = 24;
    localparam int HOP_DEF     = 8;

    typedef logic signed [15:0] sample_t;

    typedef enum logic {
        L_IDLE,
        L_BUSY
    } launch_st_e;

    // Clamp a 17-bit signed difference into the 16-bit sample range.
    // The top two bits disagree only when the result has left that range.
    function automatic sample_t sat16(input logic [16:0] x);
        sample_t r;
        unique case (x[16:15])
            2'b01:   r = 16'sh7fff;
            2'b10:   r = 16'sh8000;
            default: r = x[15:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ppg_shift_window.sv
// Sample collector: shift register (index 0 oldest), fill counter and fill
// target. Ports: s_valid/s_data/s_ready stream in, launch clears, full out.
module ppg_shift_window
    import ppg_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int HOP     = HOP_DEF,
    parameter int DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     launch,
    output logic                     s_ready,
    output logic                     full,
    output logic signed [DATA_W-1:0] sr [0:WIN_LEN-1]
);

    localparam int CNT_W = $clog2(WIN_LEN + 1);

    logic signed [DATA_W-1:0] sr_q [0:WIN_LEN-1];
    logic signed [DATA_W-1:0] sr_d [0:WIN_LEN-1];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         need_q, need_d;
    logic                     accept;

    assign s_ready = (cnt_q < need_q);
    assign full    = (cnt_q == need_q);
    assign accept  = s_valid && s_ready;
    assign sr      = sr_q;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        need_d = need_q;
        if (launch) begin
            // s_ready is low whenever launch fires, so no sample is lost.
            cnt_d  = '0;
            need_d = CNT_W'(HOP);
        end else if (accept) begin
            for (int i = 0; i < WIN_LEN - 1; i++) begin
                sr_d[i] = sr_q[i+1];
            end
            sr_d[WIN_LEN-1] = s_data;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                sr_q[i] <= '0;
            end
            cnt_q  <= '0;
            need_q <= CNT_W'(WIN_LEN);
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            need_q <= need_d;
        end
    end

endmodule

// File: rtl/ppg_window_framer.sv
// Sliding-window framer: launches a WIN_LEN snapshot with a start pulse,
// then waits for a core_done rise. Optional PPG_DC_REMOVE_EN subtracts sr[0].
module ppg_window_framer
    import ppg_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int HOP     = HOP_DEF,
    parameter int DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] win_data [0:WIN_LEN-1],
    output logic                     start,
    input  logic                     core_done,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              stall_cnt
);

    logic signed [DATA_W-1:0] sr [0:WIN_LEN-1];
    logic                     full;
    logic                     launch;

    launch_st_e               state_q, state_d;
    logic                     start_q, start_d;
    logic                     done_q, done_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;
    logic signed [DATA_W-1:0] win_q [0:WIN_LEN-1];
    logic signed [DATA_W-1:0] win_d [0:WIN_LEN-1];

    ppg_shift_window #(
        .WIN_LEN (WIN_LEN),
        .HOP     (HOP),
        .DATA_W  (DATA_W)
    ) u_win (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .launch  (launch),
        .s_ready (s_ready),
        .full    (full),
        .sr      (sr)
    );

    assign launch = (state_q == L_IDLE) && full;

    assign win_data  = win_q;
    assign start     = start_q;
    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        done_d      = core_done;
        win_d       = win_q;
        frame_cnt_d = frame_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (s_valid && !s_ready && stall_cnt_q != 16'hffff) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        unique case (state_q)
            L_IDLE: begin
                if (full) begin
                    for (int i = 0; i < WIN_LEN; i++) begin
`ifdef PPG_DC_REMOVE_EN
                        win_d[i] = sat16({sr[i][DATA_W-1], sr[i]}
                                       - {sr[0][DATA_W-1], sr[0]});
`else
                        win_d[i] = sr[i];
`endif
                    end
                    start_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = L_BUSY;
                end
            end
            L_BUSY: begin
                if (core_done && !done_q) begin
                    state_d = L_IDLE;
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= L_IDLE;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < WIN_LEN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            win_q       <= win_d;
        end
    end

endmodule
